// File: rtl/mips_16_prog_loader_pkg.sv
// Shared MIPS-16 definitions: default datapath widths and the program-loader state encoding.
package mips_16_defs;

   localparam int PC_WIDTH_DEF    = 8;
   localparam int INSTR_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERR     = 3'd5
   } loader_state_e;

endpackage

// File: rtl/mips_16_cycle_timer.sv
// Down-counting cycle timer shared by the RELEASE and RUN phases of the program loader.
module mips_16_cycle_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_expired
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;

   // Load has priority; an enabled timer counts down and parks at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= ZERO;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != ZERO)) begin
         r_count <= r_count - ONE;
      end
   end

   // Expiry marks the last cycle of the loaded interval, so a phase lasts exactly the load value.
   assign o_expired = i_en && (r_count == ONE);

endmodule

// File: rtl/mips_16_prog_loader.sv
// Streams a program into the IF-stage instruction memory, then releases the core for a fixed run window.
module mips_16_prog_loader
   import mips_16_defs::*;
#(
   parameter int PC_WIDTH    = PC_WIDTH_DEF,
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int RST_CYCLES  = 1,
   parameter int RUN_CYCLES  = 200
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   in_valid,
   input  logic [INSTR_WIDTH-1:0] in_data,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic                   imem_we,
   output logic [PC_WIDTH-1:0]    imem_addr,
   output logic [INSTR_WIDTH-1:0] imem_wdata,
   output logic                   core_rst,
   output logic [PC_WIDTH:0]      word_count,
   output logic                   load_done,
   output logic                   run_done,
   output logic                   error
);

   localparam int MAX_CYC = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
   localparam int TMR_W   = $clog2(MAX_CYC + 1) + 1;

   localparam logic [TMR_W-1:0]  RST_LOAD  = TMR_W'(RST_CYCLES);
   localparam logic [TMR_W-1:0]  RUN_LOAD  = TMR_W'(RUN_CYCLES);
   localparam logic [PC_WIDTH:0] LAST_ADDR = {1'b0, {PC_WIDTH{1'b1}}};
   localparam logic [PC_WIDTH:0] WC_ONE    = {{PC_WIDTH{1'b0}}, 1'b1};

   loader_state_e            r_state;
   logic                     r_in_ready;
   logic                     r_imem_we;
   logic [PC_WIDTH-1:0]      r_imem_addr;
   logic [INSTR_WIDTH-1:0]   r_imem_wdata;
   logic                     r_core_rst;
   logic [PC_WIDTH:0]        r_word_count;
   logic                     r_load_done;
   logic                     r_run_done;
   logic                     r_error;

   logic                     w_accept;
   logic                     w_tmr_load;
   logic [TMR_W-1:0]         w_tmr_val;
   logic                     w_tmr_en;
   logic                     w_tmr_expired;

   assign w_accept = in_valid && r_in_ready && (r_state == ST_LOAD);
   assign w_tmr_en = (r_state == ST_RELEASE) || (r_state == ST_RUN);

   // The timer is armed with the reset hold on the last accept and re-armed with the run window on leaving RELEASE.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = RST_LOAD;
      if (r_state == ST_LOAD) begin
         w_tmr_load = w_accept && in_last;
         w_tmr_val  = RST_LOAD;
      end else if (r_state == ST_RELEASE) begin
         w_tmr_load = w_tmr_expired;
         w_tmr_val  = RUN_LOAD;
      end else begin
         w_tmr_load = 1'b0;
         w_tmr_val  = RST_LOAD;
      end
   end

   mips_16_cycle_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (w_tmr_en),
      .o_expired  (w_tmr_expired)
   );

   // Loader FSM with all outputs registered; abort overrides everything and keeps the sticky flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_in_ready   <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= {PC_WIDTH{1'b0}};
         r_imem_wdata <= {INSTR_WIDTH{1'b0}};
         r_core_rst   <= 1'b1;
         r_word_count <= {(PC_WIDTH+1){1'b0}};
         r_load_done  <= 1'b0;
         r_run_done   <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_imem_we <= 1'b0;
         if (abort) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_core_rst <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE, ST_DONE, ST_ERR: begin
                  if (start) begin
                     r_state      <= ST_LOAD;
                     r_in_ready   <= 1'b1;
                     r_core_rst   <= 1'b1;
                     r_word_count <= {(PC_WIDTH+1){1'b0}};
                     r_load_done  <= 1'b0;
                     r_run_done   <= 1'b0;
                     r_error      <= 1'b0;
                  end
               end
               ST_LOAD: begin
                  if (w_accept) begin
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_word_count[PC_WIDTH-1:0];
                     r_imem_wdata <= in_data;
                     r_word_count <= r_word_count + WC_ONE;
                     // in_last on the top address is a complete program, not an overflow.
                     if (in_last) begin
                        r_state     <= ST_RELEASE;
                        r_in_ready  <= 1'b0;
                        r_load_done <= 1'b1;
                     end else if (r_word_count == LAST_ADDR) begin
                        r_state    <= ST_ERR;
                        r_in_ready <= 1'b0;
                        r_error    <= 1'b1;
                     end
                  end
               end
               ST_RELEASE: begin
                  if (w_tmr_expired) begin
                     r_state    <= ST_RUN;
                     r_core_rst <= 1'b0;
                  end
               end
               ST_RUN: begin
                  if (w_tmr_expired) begin
                     r_state    <= ST_DONE;
                     r_core_rst <= 1'b1;
                     r_run_done <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_in_ready <= 1'b0;
                  r_core_rst <= 1'b1;
               end
            endcase
         end
      end
   end

   assign in_ready   = r_in_ready;
   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign core_rst   = r_core_rst;
   assign word_count = r_word_count;
   assign load_done  = r_load_done;
   assign run_done   = r_run_done;
   assign error      = r_error;

endmodule
